// File: rtl/uart_tx_serializer.sv
// UART transmit serializer: one-byte holding register, fractional baud
// prescaler (16 ticks per bit), and a start/data/parity/stop shifter.
module uart_tx_serializer (
    input  logic        CLK,
    input  logic        RESET,
    input  logic        CSN,
    input  logic        WEN,
    input  logic [7:0]  DATA_IN,
    input  logic [12:0] BAUD_VAL,
    input  logic [2:0]  BAUD_VAL_FRACTION,
    input  logic        BIT8,
    input  logic        PARITY_EN,
    input  logic        ODD_N_EVEN,
    output logic        TX,
    output logic        TXRDY,
    output logic        TX_BUSY
);

    typedef enum logic [2:0] {StIdle, StStart, StData, StParity, StStop} state_e;

    state_e      state_q, state_d;
    logic [7:0]  hold_q, hold_d;
    logic        txrdy_q, txrdy_d;
    logic [7:0]  shift_q, shift_d;
    logic        bit8_q, bit8_d;
    logic        par_en_q, par_en_d;
    logic        par_bit_q, par_bit_d;
    logic [2:0]  bit_idx_q, bit_idx_d;
    logic [3:0]  sub_q, sub_d;
    logic [13:0] presc_q, presc_d;
    logic [2:0]  acc_q, acc_d;
    logic        tx_q, tx_d;
    logic        busy_q, busy_d;

    logic        wr;
    logic [3:0]  acc_sum;
    logic        carry;
    logic [13:0] presc_last;
    logic        tick;
    logic        bit_end;
    logic [2:0]  last_idx;
    logic        shifter_free;
    logic        xfer;

    assign wr         = !CSN && !WEN;
    // Carry out of the fraction accumulator stretches the current tick period by one clock.
    assign acc_sum    = {1'b0, acc_q} + {1'b0, BAUD_VAL_FRACTION};
    assign carry      = acc_sum[3];
    assign presc_last = {1'b0, BAUD_VAL} + {13'd0, carry};
    assign tick       = (state_q != StIdle) && (presc_q == presc_last);
    assign bit_end    = tick && (sub_q == 4'hF);
    assign last_idx   = bit8_q ? 3'd7 : 3'd6;
    // Shifter frees up on the final STOP clock so back-to-back frames have no idle gap.
    assign shifter_free = (state_q == StIdle) || ((state_q == StStop) && bit_end);
    assign xfer         = !txrdy_q && shifter_free;

    // Holding register, latched frame format, shift register and bit-rate counters.
    always_comb begin
        hold_d    = hold_q;
        txrdy_d   = txrdy_q;
        shift_d   = shift_q;
        bit8_d    = bit8_q;
        par_en_d  = par_en_q;
        par_bit_d = par_bit_q;
        sub_d     = sub_q;
        presc_d   = presc_q;
        acc_d     = acc_q;
        if (xfer) begin
            txrdy_d   = 1'b1;
            shift_d   = hold_q;
            bit8_d    = BIT8;
            par_en_d  = PARITY_EN;
            par_bit_d = (^(hold_q & {BIT8, 7'h7F})) ^ ODD_N_EVEN;
            sub_d     = 4'd0;
            presc_d   = 14'd0;
            acc_d     = 3'd0;
        end else begin
            if (wr && txrdy_q) begin
                hold_d  = DATA_IN;
                txrdy_d = 1'b0;
            end
            if (state_q == StIdle) begin
                sub_d   = 4'd0;
                presc_d = 14'd0;
                acc_d   = 3'd0;
            end else if (tick) begin
                sub_d   = sub_q + 4'd1;
                presc_d = 14'd0;
                acc_d   = acc_sum[2:0];
                if ((state_q == StData) && bit_end) begin
                    shift_d = {1'b0, shift_q[7:1]};
                end
            end else begin
                presc_d = presc_q + 14'd1;
            end
        end
    end

    // Datapath state registers.
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            hold_q    <= 8'd0;
            txrdy_q   <= 1'b1;
            shift_q   <= 8'd0;
            bit8_q    <= 1'b0;
            par_en_q  <= 1'b0;
            par_bit_q <= 1'b0;
            sub_q     <= 4'd0;
            presc_q   <= 14'd0;
            acc_q     <= 3'd0;
        end else begin
            hold_q    <= hold_d;
            txrdy_q   <= txrdy_d;
            shift_q   <= shift_d;
            bit8_q    <= bit8_d;
            par_en_q  <= par_en_d;
            par_bit_q <= par_bit_d;
            sub_q     <= sub_d;
            presc_q   <= presc_d;
            acc_q     <= acc_d;
        end
    end

    // FSM state register.
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            state_q   <= StIdle;
            bit_idx_q <= 3'd0;
        end else begin
            state_q   <= state_d;
            bit_idx_q <= bit_idx_d;
        end
    end

    // FSM next state: a transfer always restarts at START, otherwise advance on bit end.
    always_comb begin
        state_d   = state_q;
        bit_idx_d = bit_idx_q;
        if (xfer) begin
            state_d   = StStart;
            bit_idx_d = 3'd0;
        end else if (bit_end) begin
            unique case (state_q)
                StStart: begin
                    state_d   = StData;
                    bit_idx_d = 3'd0;
                end
                StData: begin
                    if (bit_idx_q == last_idx) begin
                        state_d = par_en_q ? StParity : StStop;
                    end else begin
                        bit_idx_d = bit_idx_q + 3'd1;
                    end
                end
                StParity: state_d = StStop;
                StStop:   state_d = StIdle;
                default:  state_d = StIdle;
            endcase
        end
    end

    // Output decode from the next state so TX/TX_BUSY are registered without a cycle of lag.
    always_comb begin
        tx_d   = 1'b1;
        busy_d = (state_d != StIdle);
        unique case (state_d)
            StIdle:   tx_d = 1'b1;
            StStart:  tx_d = 1'b0;
            StData:   tx_d = shift_d[0];
            StParity: tx_d = par_bit_d;
            StStop:   tx_d = 1'b1;
            default:  tx_d = 1'b1;
        endcase
    end

    // Output registers.
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            tx_q   <= 1'b1;
            busy_q <= 1'b0;
        end else begin
            tx_q   <= tx_d;
            busy_q <= busy_d;
        end
    end

    assign TX      = tx_q;
    assign TXRDY   = txrdy_q;
    assign TX_BUSY = busy_q;

endmodule

// File: tb/tb_uart_tx_serializer.sv
// Self-checking bench for uart_tx_serializer: per-clock expected TX/TXRDY/TX_BUSY
// derived from frame bit lists and tick-period arithmetic.
module tb_uart_tx_serializer;

    logic        CLK = 1'b0;
    logic        RESET;
    logic        CSN;
    logic        WEN;
    logic [7:0]  DATA_IN;
    logic [12:0] BAUD_VAL;
    logic [2:0]  BAUD_VAL_FRACTION;
    logic        BIT8;
    logic        PARITY_EN;
    logic        ODD_N_EVEN;
    logic        TX;
    logic        TXRDY;
    logic        TX_BUSY;

    int errors = 0;
    int checks = 0;

    // Scheduled in-frame events for run_frame (-1 = none).
    int         wr_at0 = -1;
    int         wr_at1 = -1;
    logic [7:0] wr_dat0 = 8'h00;
    logic [7:0] wr_dat1 = 8'h00;
    int         chg_at = -1;
    logic       chg_bit8 = 1'b1;
    logic       chg_pe = 1'b0;
    logic       chg_odd = 1'b0;

    uart_tx_serializer dut (
        .CLK               (CLK),
        .RESET             (RESET),
        .CSN               (CSN),
        .WEN               (WEN),
        .DATA_IN           (DATA_IN),
        .BAUD_VAL          (BAUD_VAL),
        .BAUD_VAL_FRACTION (BAUD_VAL_FRACTION),
        .BIT8              (BIT8),
        .PARITY_EN         (PARITY_EN),
        .ODD_N_EVEN        (ODD_N_EVEN),
        .TX                (TX),
        .TXRDY             (TXRDY),
        .TX_BUSY           (TX_BUSY)
    );

    always #5 CLK = ~CLK;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached, checks=%0d", checks);
        $fatal(1, "watchdog");
    end

    // Extra clock in tick k when the running sum k*frac crosses a multiple of 8.
    function automatic int carry_at(input int k, input int frac);
        return ((k + 1) * frac) / 8 - (k * frac) / 8;
    endfunction

    task automatic set_cfg(input int baud, input int frac, input logic b8, input logic pe,
                           input logic odd);
        BAUD_VAL          = 13'(baud);
        BAUD_VAL_FRACTION = 3'(frac);
        BIT8              = b8;
        PARITY_EN         = pe;
        ODD_N_EVEN        = odd;
    endtask

    // Called at #1 after an edge while idle: write, then expect transfer one edge later.
    task automatic start_frame(input logic [7:0] b, input string name);
        CSN = 1'b0; WEN = 1'b0; DATA_IN = b;
        @(posedge CLK); #1;
        CSN = 1'b1; WEN = 1'b1; DATA_IN = 8'($urandom);
        checks++;
        if (TXRDY !== 1'b0 || TX_BUSY !== 1'b0) begin
            errors++;
            $display("FAIL %s_write: TXRDY=%b TX_BUSY=%b, required TXRDY=0 TX_BUSY=0",
                     name, TXRDY, TX_BUSY);
        end
        @(posedge CLK); #1;
        checks++;
        if (TX !== 1'b0 || TXRDY !== 1'b1 || TX_BUSY !== 1'b1) begin
            errors++;
            $display("FAIL %s_xfer: TX=%b TXRDY=%b TX_BUSY=%b, required TX=0 TXRDY=1 TX_BUSY=1",
                     name, TX, TXRDY, TX_BUSY);
        end
    endtask

    // Called at #1 after the transfer edge; checks every clock of one frame.
    task automatic run_frame(input logic [7:0] b, input logic b8, input logic pe,
                             input logic odd, input int baud, input int frac,
                             input string name);
        logic bits[$];
        logic exp_tx[$];
        logic p;
        logic exp_rdy;
        logic acc_wr;
        int   n;
        int   k;
        int   bad;
        int   fi;
        logic f_tx, f_rdy, f_busy, e_tx, e_rdy;
        n = b8 ? 8 : 7;
        p = odd;
        bits.push_back(1'b0);
        for (int i = 0; i < n; i++) begin
            bits.push_back(b[i]);
            p = p ^ b[i];
        end
        if (pe) bits.push_back(p);
        bits.push_back(1'b1);
        k = 0;
        foreach (bits[j]) begin
            for (int t = 0; t < 16; t++) begin
                for (int c = 0; c < baud + 1 + carry_at(k, frac); c++) exp_tx.push_back(bits[j]);
                k++;
            end
        end
        exp_rdy = 1'b1;
        bad = 0;
        fi = 0; f_tx = 1'b0; f_rdy = 1'b0; f_busy = 1'b0; e_tx = 1'b0; e_rdy = 1'b0;
        for (int i = 0; i < exp_tx.size(); i++) begin
            if (TX !== exp_tx[i] || TXRDY !== exp_rdy || TX_BUSY !== 1'b1) begin
                if (bad == 0) begin
                    fi = i; f_tx = TX; f_rdy = TXRDY; f_busy = TX_BUSY;
                    e_tx = exp_tx[i]; e_rdy = exp_rdy;
                end
                bad++;
            end
            acc_wr = 1'b0;
            CSN = 1'b1; WEN = 1'b1;
            if (i == wr_at0) begin
                CSN = 1'b0; WEN = 1'b0; DATA_IN = wr_dat0; acc_wr = exp_rdy;
            end else if (i == wr_at1) begin
                CSN = 1'b0; WEN = 1'b0; DATA_IN = wr_dat1; acc_wr = exp_rdy;
            end
            if (i == chg_at) begin
                BIT8 = chg_bit8; PARITY_EN = chg_pe; ODD_N_EVEN = chg_odd;
            end
            @(posedge CLK); #1;
            if (acc_wr) exp_rdy = 1'b0;
        end
        CSN = 1'b1; WEN = 1'b1;
        wr_at0 = -1; wr_at1 = -1; chg_at = -1;
        checks++;
        if (bad != 0) begin
            errors++;
            $display("FAIL frame_%s: %0d of %0d clocks wrong, first at clock %0d: TX=%b TXRDY=%b TX_BUSY=%b, required TX=%b TXRDY=%b TX_BUSY=1",
                     name, bad, exp_tx.size(), fi, f_tx, f_rdy, f_busy, e_tx, e_rdy);
        end
    endtask

    task automatic check_idle(input string name);
        checks++;
        if (TX !== 1'b1 || TXRDY !== 1'b1 || TX_BUSY !== 1'b0) begin
            errors++;
            $display("FAIL %s_idle: TX=%b TXRDY=%b TX_BUSY=%b, required TX=1 TXRDY=1 TX_BUSY=0",
                     name, TX, TXRDY, TX_BUSY);
        end
    endtask

    task automatic check_seam(input string name);
        checks++;
        if (TX !== 1'b0 || TXRDY !== 1'b1 || TX_BUSY !== 1'b1) begin
            errors++;
            $display("FAIL %s_seam: TX=%b TXRDY=%b TX_BUSY=%b, required TX=0 TXRDY=1 TX_BUSY=1",
                     name, TX, TXRDY, TX_BUSY);
        end
    endtask

    task automatic test_reset();
        RESET = 1'b1; CSN = 1'b1; WEN = 1'b1; DATA_IN = 8'h00;
        set_cfg(0, 0, 1'b1, 1'b0, 1'b0);
        repeat (3) @(posedge CLK);
        #1;
        check_idle("reset");
        RESET = 1'b0;
        @(posedge CLK); #1;
        check_idle("after_reset");
    endtask

    task automatic test_basic_8n1();
        set_cfg(0, 0, 1'b1, 1'b0, 1'b0);
        start_frame(8'h55, "basic");
        run_frame(8'h55, 1'b1, 1'b0, 1'b0, 0, 0, "basic_55");
        check_idle("basic");
    endtask

    task automatic test_parity();
        set_cfg(2, 0, 1'b0, 1'b1, 1'b0);
        start_frame(8'hFF, "even");
        run_frame(8'hFF, 1'b0, 1'b1, 1'b0, 2, 0, "7e1_ff");
        check_idle("even");
        ODD_N_EVEN = 1'b1;
        start_frame(8'hFF, "odd");
        run_frame(8'hFF, 1'b0, 1'b1, 1'b1, 2, 0, "7o1_ff");
        check_idle("odd");
    endtask

    task automatic test_back_to_back();
        set_cfg(1, 0, 1'b1, 1'b0, 1'b0);
        start_frame(8'hA5, "b2b");
        wr_at0 = 40;  wr_dat0 = 8'h3C;
        wr_at1 = 100; wr_dat1 = 8'h99;
        run_frame(8'hA5, 1'b1, 1'b0, 1'b0, 1, 0, "b2b_a5");
        check_seam("b2b");
        run_frame(8'h3C, 1'b1, 1'b0, 1'b0, 1, 0, "b2b_3c");
        begin
            int bad = 0;
            for (int i = 0; i < 64; i++) begin
                if (TX !== 1'b1 || TX_BUSY !== 1'b0) bad++;
                @(posedge CLK); #1;
            end
            checks++;
            if (bad != 0) begin
                errors++;
                $display("FAIL b2b_dropped: %0d busy clocks after second frame, required 0", bad);
            end
        end
    endtask

    task automatic test_fraction();
        int n = 0;
        int z = -1;
        set_cfg(3, 3, 1'b1, 1'b0, 1'b0);
        start_frame(8'hFF, "frac");
        while (TX_BUSY === 1'b1 && n < 3000) begin
            if (TX !== 1'b0 && z < 0) z = n;
            n++;
            @(posedge CLK); #1;
        end
        checks++;
        if (z != 70) begin
            errors++;
            $display("FAIL frac_start_bit: start bit lasted %0d clocks, required 70", z);
        end
        checks++;
        if (n != 700) begin
            errors++;
            $display("FAIL frac_frame_len: frame lasted %0d clocks, required 700", n);
        end
        set_cfg(3, 3, 1'b1, 1'b1, 1'b0);
        start_frame(8'h6B, "frac_model");
        run_frame(8'h6B, 1'b1, 1'b1, 1'b0, 3, 3, "frac_6b");
        check_idle("frac");
    endtask

    task automatic test_mid_reset();
        set_cfg(1, 0, 1'b1, 1'b0, 1'b0);
        start_frame(8'hF0, "mreset");
        for (int i = 0; i < 70; i++) begin
            CSN = (i == 40) ? 1'b0 : 1'b1;
            WEN = (i == 40) ? 1'b0 : 1'b1;
            DATA_IN = 8'h77;
            @(posedge CLK); #1;
        end
        CSN = 1'b1; WEN = 1'b1;
        checks++;
        if (TX !== 1'b0 || TXRDY !== 1'b0 || TX_BUSY !== 1'b1) begin
            errors++;
            $display("FAIL mreset_pre: TX=%b TXRDY=%b TX_BUSY=%b, required TX=0 TXRDY=0 TX_BUSY=1",
                     TX, TXRDY, TX_BUSY);
        end
        #2;
        RESET = 1'b1;
        #1;
        check_idle("mreset_async");
        @(posedge CLK); #1;
        RESET = 1'b0;
        begin
            int bad = 0;
            for (int i = 0; i < 20; i++) begin
                if (TX !== 1'b1 || TXRDY !== 1'b1 || TX_BUSY !== 1'b0) bad++;
                @(posedge CLK); #1;
            end
            checks++;
            if (bad != 0) begin
                errors++;
                $display("FAIL mreset_holding: %0d non-idle clocks after reset, required 0", bad);
            end
        end
        start_frame(8'h01, "mreset_new");
        run_frame(8'h01, 1'b1, 1'b0, 1'b0, 1, 0, "mreset_01");
        check_idle("mreset_new");
    endtask

    task automatic test_format_change();
        set_cfg(0, 0, 1'b1, 1'b0, 1'b0);
        start_frame(8'hC3, "fmt");
        chg_at = 20; chg_bit8 = 1'b0; chg_pe = 1'b1; chg_odd = 1'b1;
        wr_at0 = 50; wr_dat0 = 8'h80;
        run_frame(8'hC3, 1'b1, 1'b0, 1'b0, 0, 0, "fmt_old");
        check_seam("fmt");
        run_frame(8'h80, 1'b0, 1'b1, 1'b1, 0, 0, "fmt_new");
        check_idle("fmt");
    endtask

    task automatic test_random();
        for (int it = 0; it < 8; it++) begin
            logic [7:0] b;
            logic b8, pe, odd;
            int baud, frac;
            b    = 8'($urandom);
            b8   = 1'($urandom);
            pe   = 1'($urandom);
            odd  = 1'($urandom);
            baud = int'($urandom_range(0, 3));
            frac = int'($urandom_range(0, 7));
            set_cfg(baud, frac, b8, pe, odd);
            start_frame(b, "rand");
            run_frame(b, b8, pe, odd, baud, frac, "rand");
            check_idle("rand");
        end
    endtask

    initial begin
        test_reset();
        test_basic_8n1();
        test_parity();
        test_back_to_back();
        test_fraction();
        test_mid_reset();
        test_format_change();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
